operand_loader: RTL and testbench

//  Parametrised operand loader. Assembles NUM_OPS operands of DATA_W bits from a UART

---
 rtl/operand_loader_pkg.sv | 23 ++
 rtl/operand_loader_byte_shift_reg.sv | 47 ++++
 rtl/operand_loader.sv | 203 ++++++++++++++++++++
 tb/tb_operand_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_loader_pkg.sv
// Shared types and sizing helpers for the operand loader.
// Optional checksum stage is enabled by defining OPERAND_LOADER_CHECKSUM_EN.
package operand_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  function automatic int calc_bpo(input int data_w);
    return data_w / BYTE_W;
  endfunction

  // Counters always get at least one bit, even when they only ever hold 0.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/operand_loader_byte_shift_reg.sv
// Shadow register for one operand: clears, or shifts a byte in from the LSB end.
// Exposes its next value so the final byte can be committed on the same edge.
module byte_shift_reg
  import operand_loader_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr_in,
  input  logic              shift_in,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] data_nxt_out
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] shifted;

  generate
    if (DATA_W == BYTE_W) begin : g_single
      assign shifted = byte_in;
    end else begin : g_multi
      assign shifted = {data_q[DATA_W-BYTE_W-1:0], byte_in};
    end
  endgenerate

  always_comb begin
    data_d = data_q;
    if (clr_in) begin
      data_d = '0;
    end else if (shift_in) begin
      data_d = shifted;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_nxt_out = data_d;

endmodule

// File: rtl/operand_loader.sv
// Assembles NUM_OPS operands from an MSB-first UART byte stream; valid/ack handoff.
// Define OPERAND_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int NUM_OPS = 2
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start_in,
  input  logic                      rx_valid_in,
  input  logic [BYTE_W-1:0]         Rx_Byte_in,
  input  logic                      ops_ack_in,
  output logic                      rx_ready_out,
  output logic [NUM_OPS*DATA_W-1:0] ops_out,
  output logic                      ops_valid_out,
  output logic                      busy_out,
  output logic                      err_overrun_out,
  output logic                      err_abort_out,
  output logic                      err_chksum_out
);

  localparam int BPO   = calc_bpo(DATA_W);
  localparam int BC_W  = cnt_w(BPO);
  localparam int OP_W  = cnt_w(NUM_OPS);
  localparam int OPS_W = NUM_OPS * DATA_W;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPO - 1);
  localparam logic [OP_W-1:0] OP_LAST = OP_W'(NUM_OPS - 1);

  state_t            state_q, state_d;
  logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [OP_W-1:0]   op_idx_q, op_idx_d;
  logic [OPS_W-1:0]  ops_q, ops_d;
  logic              err_overrun_q, err_overrun_d;
  logic              err_abort_q, err_abort_d;
  logic              err_chksum_q, err_chksum_d;
  logic              shadow_clr;
  logic              byte_take;
  logic [NUM_OPS-1:0] shift_en;
  logic [OPS_W-1:0]  shadow_nxt;

`ifdef OPERAND_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] xor_q, xor_d;
`endif

  for (genvar k = 0; k < NUM_OPS; k++) begin : g_op
    assign shift_en[k] = byte_take && (op_idx_q == OP_W'(k));

    byte_shift_reg #(.DATA_W(DATA_W)) u_shreg (
      .CLK          (CLK),
      .RST          (RST),
      .clr_in       (shadow_clr),
      .shift_in     (shift_en[k]),
      .byte_in      (Rx_Byte_in),
      .data_nxt_out (shadow_nxt[k*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    op_idx_d      = op_idx_q;
    ops_d         = ops_q;
    err_overrun_d = 1'b0;
    err_abort_d   = 1'b0;
    err_chksum_d  = 1'b0;
    shadow_clr    = 1'b0;
    byte_take     = 1'b0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
    xor_d         = xor_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d    = LOAD;
          byte_cnt_d = '0;
          op_idx_d   = '0;
          shadow_clr = 1'b1;
`ifdef OPERAND_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end

      LOAD: begin
        if (start_in) begin
          // Restart wins over any byte arriving in the same cycle.
          err_abort_d = 1'b1;
          byte_cnt_d  = '0;
          op_idx_d    = '0;
          shadow_clr  = 1'b1;
`ifdef OPERAND_LOADER_CHECKSUM_EN
          xor_d       = '0;
`endif
        end else if (rx_valid_in) begin
          byte_take = 1'b1;
`ifdef OPERAND_LOADER_CHECKSUM_EN
          xor_d     = xor_q ^ Rx_Byte_in;
`endif
          if (byte_cnt_q == BC_LAST) begin
            byte_cnt_d = '0;
            if (op_idx_q == OP_LAST) begin
              op_idx_d = '0;
`ifdef OPERAND_LOADER_CHECKSUM_EN
              state_d  = CHK;
`else
              state_d  = HOLD;
              ops_d    = shadow_nxt;
`endif
            end else begin
              op_idx_d = op_idx_q + 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      CHK: begin
`ifdef OPERAND_LOADER_CHECKSUM_EN
        if (start_in) begin
          state_d     = LOAD;
          err_abort_d = 1'b1;
          byte_cnt_d  = '0;
          op_idx_d    = '0;
          shadow_clr  = 1'b1;
          xor_d       = '0;
        end else if (rx_valid_in) begin
          if (Rx_Byte_in == xor_q) begin
            state_d = HOLD;
            ops_d   = shadow_nxt;
          end else begin
            state_d      = IDLE;
            err_chksum_d = 1'b1;
          end
        end
`else
        state_d = IDLE;
`endif
      end

      HOLD: begin
        err_overrun_d = rx_valid_in;
        if (ops_ack_in) begin
          if (start_in) begin
            state_d    = LOAD;
            byte_cnt_d = '0;
            op_idx_d   = '0;
            shadow_clr = 1'b1;
`ifdef OPERAND_LOADER_CHECKSUM_EN
            xor_d      = '0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      op_idx_q      <= '0;
      ops_q         <= '0;
      err_overrun_q <= 1'b0;
      err_abort_q   <= 1'b0;
      err_chksum_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      op_idx_q      <= op_idx_d;
      ops_q         <= ops_d;
      err_overrun_q <= err_overrun_d;
      err_abort_q   <= err_abort_d;
      err_chksum_q  <= err_chksum_d;
    end
  end

`ifdef OPERAND_LOADER_CHECKSUM_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

  assign ops_out         = ops_q;
  assign ops_valid_out   = (state_q == HOLD);
  assign busy_out        = (state_q != IDLE);
  assign rx_ready_out    = (state_q == LOAD) || (state_q == CHK);
  assign err_overrun_out = err_overrun_q;
  assign err_abort_out   = err_abort_q;
  assign err_chksum_out  = err_chksum_q;

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: 16x2 instance plus a 24x3 instance.
// Follows OPERAND_LOADER_CHECKSUM_EN to send and expect the trailing checksum byte.
module tb_operand_loader;

  localparam int DW  = 16;
  localparam int NO  = 2;
  localparam int OW  = DW * NO;
  localparam int DW3 = 24;
  localparam int NO3 = 3;
  localparam int OW3 = DW3 * NO3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start, rx_valid, ack;
  logic [7:0]    rx_byte;
  logic          rx_ready, ops_valid, busy, e_ovr, e_abt, e_chk;
  logic [OW-1:0] ops;

  logic           start3, rx_valid3, ack3;
  logic [7:0]     rx_byte3;
  logic           rx_ready3, ops_valid3, busy3, e_ovr3, e_abt3, e_chk3;
  logic [OW3-1:0] ops3;

  operand_loader #(.DATA_W(DW), .NUM_OPS(NO)) u_dut (
    .CLK(clk), .RST(rst), .start_in(start), .rx_valid_in(rx_valid),
    .Rx_Byte_in(rx_byte), .ops_ack_in(ack), .rx_ready_out(rx_ready),
    .ops_out(ops), .ops_valid_out(ops_valid), .busy_out(busy),
    .err_overrun_out(e_ovr), .err_abort_out(e_abt), .err_chksum_out(e_chk)
  );

  operand_loader #(.DATA_W(DW3), .NUM_OPS(NO3)) u_dut3 (
    .CLK(clk), .RST(rst), .start_in(start3), .rx_valid_in(rx_valid3),
    .Rx_Byte_in(rx_byte3), .ops_ack_in(ack3), .rx_ready_out(rx_ready3),
    .ops_out(ops3), .ops_valid_out(ops_valid3), .busy_out(busy3),
    .err_overrun_out(e_ovr3), .err_abort_out(e_abt3), .err_chksum_out(e_chk3)
  );

  int            n_checks = 0;
  int            n_errors = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] exp_v;
  logic [OW-1:0] last_ops = '0;
  int            ovr_cnt = 0;
  int            abt_cnt = 0;
  int            chk_cnt = 0;
  logic          valid_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  // frame holds the bytes in send order, first byte in [31:24].
  task automatic send_data(input logic [31:0] frame, input logic good_chk);
    logic [7:0]    b;
    logic [7:0]    x;
    logic [OW-1:0] e;
    x = 8'h00;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      b = frame[31-8*i -: 8];
      x = x ^ b;
      e[(i/2)*DW + (1-(i%2))*8 +: 8] = b;
      send_byte(b);
    end
`ifdef OPERAND_LOADER_CHECKSUM_EN
    send_byte(good_chk ? x : (x ^ 8'h01));
`endif
    if (good_chk) begin
      exp_q.push_back(e);
      last_ops = e;
    end
  endtask

  task automatic send_frame(input logic [31:0] frame, input logic good_chk);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_data(frame, good_chk);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  always @(negedge clk) begin
    if (e_ovr) ovr_cnt++;
    if (e_abt) abt_cnt++;
    if (e_chk) chk_cnt++;
    if (ops_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 96'(exp_q.size()), 96'd1);
      end else begin
        exp_v = exp_q.pop_front();
        check_eq("sb_ops", 96'(ops), 96'(exp_v));
      end
    end
    valid_prev = ops_valid;
  end

  initial begin
    int ov0, ab0, ck0;
    logic [31:0] f;
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00; ack = 1'b0;
    start3 = 1'b0; rx_valid3 = 1'b0; rx_byte3 = 8'h00; ack3 = 1'b0;
    repeat (2) tick();
    check_eq("rst_ops", 96'(ops), 96'd0);
    check_eq("rst_valid", 96'(ops_valid), 96'd0);
    check_eq("rst_busy", 96'(busy), 96'd0);
    check_eq("rst_ready", 96'(rx_ready), 96'd0);
    rst = 1'b1;
    tick();

    // reset in the middle of a frame
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'h12); send_byte(8'h34);
    check_eq("midload_busy", 96'(busy), 96'd1);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    check_eq("midrst_ops", 96'(ops), 96'd0);
    check_eq("midrst_valid", 96'(ops_valid), 96'd0);
    check_eq("midrst_busy", 96'(busy), 96'd0);
    tick();

    // basic frame
    send_frame(32'h1234ABCD, 1'b1);
    check_eq("frame1_valid", 96'(ops_valid), 96'd1);
    check_eq("frame1_ops", 96'(ops), 96'h0000_0000_0000_0000_ABCD_1234);
    check_eq("hold_ready", 96'(rx_ready), 96'd0);

    // byte during HOLD
    ov0 = ovr_cnt;
    send_byte(8'h55);
    tick();
    check_eq("overrun_pulse", 96'(ovr_cnt - ov0), 96'd1);
    check_eq("overrun_ops", 96'(ops), 96'hABCD_1234);
    check_eq("overrun_valid", 96'(ops_valid), 96'd1);

    // start in HOLD without ack is ignored
    ab0 = abt_cnt;
    start = 1'b1; tick(); start = 1'b0; tick();
    check_eq("hold_start_valid", 96'(ops_valid), 96'd1);
    check_eq("hold_start_noabort", 96'(abt_cnt - ab0), 96'd0);

    do_ack();
    check_eq("ack_valid", 96'(ops_valid), 96'd0);
    check_eq("ack_busy", 96'(busy), 96'd0);
    check_eq("ack_ops_kept", 96'(ops), 96'hABCD_1234);

    // bytes in IDLE are ignored silently
    ov0 = ovr_cnt;
    send_byte(8'h77);
    tick();
    check_eq("idle_no_overrun", 96'(ovr_cnt - ov0), 96'd0);
    check_eq("idle_busy", 96'(busy), 96'd0);

    // restart mid-load, with a byte in the restart cycle
    ab0 = abt_cnt;
    start = 1'b1; tick(); start = 1'b0;
    send_byte(8'h12); send_byte(8'h34);
    start = 1'b1; rx_valid = 1'b1; rx_byte = 8'h99;
    tick();
    start = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    send_data(32'h56789ABC, 1'b1);
    check_eq("abort_pulse", 96'(abt_cnt - ab0), 96'd1);
    check_eq("abort_ops", 96'(ops), 96'h9ABC_5678);

    // ack and start in the same cycle go straight to LOAD
    ack = 1'b1; start = 1'b1;
    tick();
    ack = 1'b0; start = 1'b0;
    check_eq("ackstart_busy", 96'(busy), 96'd1);
    check_eq("ackstart_ready", 96'(rx_ready), 96'd1);
    check_eq("ackstart_valid", 96'(ops_valid), 96'd0);
    send_data(32'h11223344, 1'b1);
    check_eq("ackstart_ops", 96'(ops), 96'h3344_1122);
    do_ack();
    tick();

    for (int n = 0; n < 4; n++) begin
      f = $urandom;
      send_frame(f, 1'b1);
      repeat ($urandom_range(0, 3)) tick();
      do_ack();
      tick();
    end

`ifdef OPERAND_LOADER_CHECKSUM_EN
    ck0 = chk_cnt;
    send_frame(32'h1234ABCD, 1'b0);
    tick();
    check_eq("chk_bad_pulse", 96'(chk_cnt - ck0), 96'd1);
    check_eq("chk_bad_valid", 96'(ops_valid), 96'd0);
    check_eq("chk_bad_busy", 96'(busy), 96'd0);
    check_eq("chk_bad_ops", 96'(ops), 96'(last_ops));
    send_frame(32'h1234ABCD, 1'b1);
    check_eq("chk_good_valid", 96'(ops_valid), 96'd1);
    do_ack();
`else
    ck0 = 0;
    check_eq("no_chk_err", 96'(chk_cnt - ck0), 96'd0);
`endif

    // 24-bit x 3 instance
    start3 = 1'b1; tick(); start3 = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      rx_valid3 = 1'b1;
      rx_byte3  = 8'(i);
      tick();
    end
`ifdef OPERAND_LOADER_CHECKSUM_EN
    rx_byte3 = 8'h01;
    tick();
`endif
    rx_valid3 = 1'b0;
    rx_byte3  = 8'h00;
    check_eq("w24_valid", 96'(ops_valid3), 96'd1);
    check_eq("w24_ops", 96'(ops3), 96'h07_0809_0405_0601_0203);
    ack3 = 1'b1; start3 = 1'b1;
    tick();
    ack3 = 1'b0; start3 = 1'b0;
    check_eq("w24_ackstart_busy", 96'(busy3), 96'd1);
    check_eq("w24_ackstart_ready", 96'(rx_ready3), 96'd1);
    check_eq("w24_ackstart_valid", 96'(ops_valid3), 96'd0);
    check_eq("w24_ops_kept", 96'(ops3), 96'h07_0809_0405_0601_0203);

    tick();
    check_eq("sb_empty", 96'(exp_q.size()), 96'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
